// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          ILEN    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory-side and core-side handshake signals of the fetch stage.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [31:0]     instr_pc;
  logic            instr_ready;
  logic            redirect;
  logic [31:0]     redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Entry storage; cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch stage: issue/credit/discard control around fetch_fifo.
// Optional FETCH_PERF_CNT_EN adds a saturating stall_cnt output.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_W = DEPTH[CW:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_pend;
  logic [CW-1:0] r_disc;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_fill;
  logic [CW:0]   w_owed;
  logic          w_req;
  logic          w_grant;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // Credits: FIFO space must cover every live request, and the response
  // counters must never exceed DEPTH.
  assign w_fill  = {1'b0, w_count} + {1'b0, r_pend};
  assign w_owed  = {1'b0, r_pend} + {1'b0, r_disc};
  assign w_req   = !rst && !bus.redirect && (w_fill < DEPTH_W) && (w_owed < DEPTH_W);
  assign w_grant = w_req && bus.imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp  = bus.imem_rvalid && ((r_pend != '0) || (r_disc != '0));
  assign w_drop  = bus.imem_rvalid && (r_disc != '0);
  assign w_push  = bus.imem_rvalid && (r_disc == '0) && (r_pend != '0) && !bus.redirect;
  assign w_pop   = bus.instr_valid && bus.instr_ready;

  assign w_push_data = '{pc: r_resp_pc, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  // Fetch/response PCs and the pending/discard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_pend     <= '0;
      r_disc     <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= align_pc(bus.redirect_pc);
      r_resp_pc  <= align_pc(bus.redirect_pc);
      r_pend     <= '0;
      r_disc     <= r_disc + r_pend - CW'(w_resp);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + PC_STEP;
      end
      if (w_drop) begin
        r_disc <= r_disc - CW'(1);
      end
      r_pend <= r_pend + CW'(w_grant) - CW'(w_push);
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = (w_count != '0) && !bus.redirect;
  assign bus.instr       = w_head.instr;
  assign bus.instr_pc    = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Cycles without an instruction for the core, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (!bus.instr_valid && !bus.redirect && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  instr_fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // memory model configuration (written by the test sequence only)
  int gnt_dly_max = 0;
  bit gnt_off     = 1'b0;
  int lat_min     = 1;
  int lat_max     = 1;

  // memory model state (written by the model only)
  int unsigned  cyc = 0;
  int unsigned  last_due = 0;
  int           gnt_wait = 0;
  int           grant_cnt = 0;
  bit           prev_stall = 1'b0;
  logic [31:0]  prev_addr = 32'h0;
  logic [31:0]  q_addr [$];
  int unsigned  q_due [$];
  logic [31:0]  pop_pc [$];
  logic [31:0]  pop_ins [$];

  initial begin : mem_model
    int unsigned due;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        q_addr.delete();
        q_due.delete();
        bus.imem_rvalid = 1'b0;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      @(negedge clk);
      if (rst) begin
        bus.imem_gnt = 1'b0;
        gnt_wait     = 0;
        grant_cnt    = 0;
        prev_stall   = 1'b0;
        pop_pc.delete();
        pop_ins.delete();
      end else begin
        if (bus.imem_req && !gnt_off) begin
          if (prev_stall) chk("addr_hold", bus.imem_addr, prev_addr);
          if (gnt_wait == 0) begin
            bus.imem_gnt = 1'b1;
            grant_cnt++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(bus.imem_addr);
            q_due.push_back(due);
            gnt_wait   = (gnt_dly_max == 0) ? 0 : $urandom_range(gnt_dly_max, 0);
            prev_stall = 1'b0;
          end else begin
            bus.imem_gnt = 1'b0;
            gnt_wait--;
            prev_stall = 1'b1;
            prev_addr  = bus.imem_addr;
          end
        end else begin
          bus.imem_gnt = 1'b0;
          prev_stall   = 1'b0;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          pop_pc.push_back(bus.instr_pc);
          pop_ins.push_back(bus.instr);
        end
      end
    end
  end

  // a response must never arrive with nothing outstanding
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(bus.imem_rvalid && dut.r_pend == '0 && dut.r_disc == '0))
        else $error("FAIL protocol: rvalid with no outstanding request");
    end
  end

  task automatic do_reset(input logic ready);
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = ready;
    gnt_dly_max     = 0;
    gnt_off         = 1'b0;
    lat_min         = 1;
    lat_max         = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", bus.imem_req, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", bus.instr_valid, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int k = 0;
    while (pop_pc.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, (pop_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int k, input int budget);
    k = 0;
    while (!bus.instr_valid && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp2 [6];
    int k;
    int npop;
    exp2 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // streaming: always grant, 1-cycle response, core always ready
    do_reset(1'b1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      if (n == 0) begin
        chk("s_req0", bus.imem_req, 32'd1);
        chk("s_addr0", bus.imem_addr, 32'h0);
      end
      if (n < 2) begin
        chk("s_nvalid", bus.instr_valid, 32'd0);
      end else begin
        chk("s_valid", bus.instr_valid, 32'd1);
        chk("s_pc", bus.instr_pc, 32'(4 * (n - 2)));
        chk("s_data", bus.instr, mem_word(32'(4 * (n - 2))));
      end
    end

    // back-pressure: FIFO fills with exactly DEPTH grants, then drains in order
    do_reset(1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk("bp_grants", grant_cnt, 32'd4);
    chk("bp_req_low", bus.imem_req, 32'd0);
    chk("bp_valid", bus.instr_valid, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    wait_pops("bp_pops", 6, 60);
    for (int i = 0; i < 6; i++) begin
      if (pop_pc.size() > i) begin
        chk("bp_pc", pop_pc[i], exp2[i]);
        chk("bp_data", pop_ins[i], mem_word(exp2[i]));
      end
    end

    // random grant/response latency and random consumer back-pressure
    do_reset(1'b1);
    gnt_dly_max = 5;
    lat_min     = 1;
    lat_max     = 6;
    k = 0;
    while (pop_pc.size() < 24 && k < 1500) begin
      @(posedge clk);
      #1;
      bus.instr_ready = 1'($urandom_range(1, 0));
      k++;
    end
    chk("rnd_pops", (pop_pc.size() >= 24) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 24; i++) begin
      if (pop_pc.size() > i) begin
        chk("rnd_pc", pop_pc[i], 32'(4 * i));
        chk("rnd_data", pop_ins[i], mem_word(32'(4 * i)));
      end
    end

    // redirect with three requests in flight
    do_reset(1'b1);
    lat_min = 5;
    lat_max = 5;
    repeat (3) @(negedge clk);
    #1;
    chk("rd_inflight", q_addr.size(), 32'd3);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    @(negedge clk);
    #1;
    chk("rd_valid_low", bus.instr_valid, 32'd0);
    chk("rd_req_low", bus.imem_req, 32'd0);
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    @(negedge clk);
    #1;
    chk("rd_disc", 32'(dut.r_disc), 32'd3);
    chk("rd_pend", 32'(dut.r_pend), 32'd0);
    chk("rd_addr", bus.imem_addr, 32'h0000_1000);
    wait_valid(k, 40);
    chk("rd_latency", k, 32'd6);
    wait_pops("rd_pops", 2, 20);
    if (pop_pc.size() > 1) begin
      chk("rd_pc0", pop_pc[0], 32'h0000_1000);
      chk("rd_data0", pop_ins[0], mem_word(32'h0000_1000));
      chk("rd_pc1", pop_pc[1], 32'h0000_1004);
    end

    // redirect coinciding with a response and a would-be pop
    do_reset(1'b1);
    lat_min = 2;
    lat_max = 2;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    #1;
    chk("rc_valid_low", bus.instr_valid, 32'd0);
    npop = pop_pc.size();
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    @(negedge clk);
    #1;
    chk("rc_empty", bus.instr_valid, 32'd0);
    chk("rc_disc", 32'(dut.r_disc), 32'd1);
    chk("rc_addr", bus.imem_addr, 32'h0000_0200);
    wait_valid(k, 40);
    chk("rc_latency", k, 32'd3);
    wait_pops("rc_pops", npop + 1, 20);
    if (pop_pc.size() > npop) begin
      chk("rc_pc", pop_pc[npop], 32'h0000_0200);
      chk("rc_data", pop_ins[npop], mem_word(32'h0000_0200));
    end

`ifdef FETCH_PERF_CNT_EN
    // starved core: memory never grants
    do_reset(1'b1);
    gnt_off = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("perf_stall", stall_cnt, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
